// File: rtl/alu_cmd_if.sv
// ----------------------------------------------------------------------------
// alu_cmd_if
// Purpose : bundles the ALU command channel and the response channel
//           (both valid/ready) between the transactor side and the responder.
// Parameters:
//   DATA_W  operand width; the result is 2*DATA_W wide
//   TAG_W   transaction tag width
// Signals:
//   cmd_valid/cmd_ready          command handshake
//   cmd_op[2:0], cmd_a, cmd_b    opcode and operands
//   cmd_tag                      tag echoed back in the response
//   rsp_valid/rsp_ready          response handshake
//   rsp_result, rsp_tag, rsp_err response payload
//   rsp_parity                   even parity over the payload; it exists only
//                                when ALU_RSP_PARITY_EN is defined
// Modports:
//   master  command initiator / response consumer
//   slave   responder
// ----------------------------------------------------------------------------
interface alu_cmd_if #(
  parameter int DATA_W = 8,
  parameter int TAG_W  = 4
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [2:0]            cmd_op;
  logic [DATA_W-1:0]     cmd_a;
  logic [DATA_W-1:0]     cmd_b;
  logic [TAG_W-1:0]      cmd_tag;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [2*DATA_W-1:0]   rsp_result;
  logic [TAG_W-1:0]      rsp_tag;
  logic                  rsp_err;
`ifdef ALU_RSP_PARITY_EN
  logic                  rsp_parity;
`endif

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_tag, rsp_err
`ifdef ALU_RSP_PARITY_EN
    , input rsp_parity
`endif
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_tag, rsp_err
`ifdef ALU_RSP_PARITY_EN
    , output rsp_parity
`endif
  );
endinterface

// File: rtl/alu_cmd_responder.sv
// ----------------------------------------------------------------------------
// alu_cmd_responder
// Purpose : takes one ALU command at a time (NOP/ADD/AND/XOR/MUL), executes
//           it (MUL is multi-cycle) and returns result + tag on a valid/ready
//           response channel. Illegal opcodes 5-7 respond with rsp_err=1.
// Optional: ALU_RSP_PARITY_EN adds a registered even-parity bit rsp_parity
//           over {rsp_err, rsp_tag, rsp_result}.
// Parameters:
//   DATA_W   operand width (result is 2*DATA_W)
//   TAG_W    tag width
//   MUL_LAT  multiply latency in EXEC cycles, 1..15
// Ports:
//   clk      clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      alu_cmd_if.slave: command and response channels
// ----------------------------------------------------------------------------
module alu_cmd_responder #(
  parameter int DATA_W  = 8,
  parameter int TAG_W   = 4,
  parameter int MUL_LAT = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  alu_cmd_if.slave   bus
);
  localparam int RES_W = 2 * DATA_W;
  localparam int CNT_W = 4;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_MUL = 3'd4;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [2:0]         op_reg;
  logic [DATA_W-1:0]  a_reg, b_reg;
  logic [TAG_W-1:0]   tag_reg;
  logic [RES_W-1:0]   result_reg;
  logic [TAG_W-1:0]   rsp_tag_reg;
  logic               err_reg;
  logic               load_rsp;
  logic               accept;
  logic [RES_W-1:0]   result_calc;
  logic               err_calc;
  logic [RES_W-1:0]   a_ext, b_ext;

  // cmd_ready is qualified with reset_n so it drops the instant reset asserts
  assign bus.cmd_ready  = reset_n && (state_reg == IDLE);
  assign bus.rsp_valid  = (state_reg == RESP);
  assign bus.rsp_result = result_reg;
  assign bus.rsp_tag    = rsp_tag_reg;
  assign bus.rsp_err    = err_reg;

  assign accept = bus.cmd_valid && (state_reg == IDLE);
  assign a_ext  = {{DATA_W{1'b0}}, a_reg};
  assign b_ext  = {{DATA_W{1'b0}}, b_reg};

  // Operates on the captured operands so the initiator may change cmd_* freely
  always_comb begin
    result_calc = '0;
    err_calc    = 1'b0;
    case (op_reg)
      OP_NOP: result_calc = '0;
      OP_ADD: result_calc = a_ext + b_ext;   // carry lands in bit DATA_W
      OP_AND: result_calc = a_ext & b_ext;
      OP_XOR: result_calc = a_ext ^ b_ext;
      OP_MUL: result_calc = a_ext * b_ext;
      default: err_calc   = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    load_rsp   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.cmd_valid) begin
          state_next = EXEC;
          // MUL stays MUL_LAT cycles in EXEC, everything else exactly one
          cnt_next   = (bus.cmd_op == OP_MUL) ? CNT_W'(MUL_LAT - 1) : '0;
        end
      end
      EXEC: begin
        if (cnt_reg == '0) begin
          load_rsp   = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      op_reg      <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      tag_reg     <= '0;
      result_reg  <= '0;
      rsp_tag_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        op_reg  <= bus.cmd_op;
        a_reg   <= bus.cmd_a;
        b_reg   <= bus.cmd_b;
        tag_reg <= bus.cmd_tag;
      end
      // response regs only load on EXEC exit, so they hold while RESP stalls
      if (load_rsp) begin
        result_reg  <= result_calc;
        rsp_tag_reg <= tag_reg;
        err_reg     <= err_calc;
      end
    end
  end

`ifdef ALU_RSP_PARITY_EN
  logic parity_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_reg <= 1'b0;
    end else if (load_rsp) begin
      parity_reg <= ^{err_calc, tag_reg, result_calc};
    end
  end

  assign bus.rsp_parity = parity_reg;
`endif

endmodule

// File: tb/tb_alu_cmd_responder.sv
// ----------------------------------------------------------------------------
// tb_alu_cmd_responder
// Scoreboard bench: the command driver pushes the reference-model response on
// acceptance, an independent monitor pops and compares on each response
// handshake, and also checks latency, hold stability and busy/idle readiness.
// ----------------------------------------------------------------------------
module tb_alu_cmd_responder;
  localparam int DATA_W  = 8;
  localparam int TAG_W   = 4;
  localparam int MUL_LAT = 3;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  tag;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  logic clk;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   hold_left = 0;
  exp_t sb_q[$];

  alu_cmd_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  alu_cmd_responder #(.DATA_W(DATA_W), .TAG_W(TAG_W), .MUL_LAT(MUL_LAT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference behaviour from the opcode table, using plain integer arithmetic
  function automatic void model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                output logic [15:0] r, output logic e, output int lat);
    int ai = int'(a);
    int bi = int'(b);
    e   = 1'b0;
    lat = 2;
    case (op)
      3'd0: r = 16'd0;
      3'd1: r = 16'(ai + bi);
      3'd2: r = 16'(ai & bi);
      3'd3: r = 16'(ai ^ bi);
      3'd4: begin r = 16'(ai * bi); lat = 1 + MUL_LAT; end
      default: begin r = 16'd0; e = 1'b1; end
    endcase
  endfunction

  // Drives a command and returns right after the accepting edge (+2)
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic [3:0] tag);
    exp_t e;
    int waited = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_tag   = tag;
    @(negedge clk);
    while (!bus.cmd_ready) begin
      waited++;
      if (waited > 300) begin
        check("cmd_accept_timeout", 32'd1, 32'd0);
        bus.cmd_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    model(op, a, b, e.res, e.err, e.lat);
    e.tag = tag;
    e.acc = cyc + 1;
    sb_q.push_back(e);
    $display("cmd op=%0d a=%02h b=%02h tag=%0d", op, a, b, tag);
    @(posedge clk);
    #2;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'($urandom);
    bus.cmd_a     = 8'($urandom);
    bus.cmd_b     = 8'($urandom);
    bus.cmd_tag   = 4'($urandom);
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue_empty", 32'(sb_q.size()), 32'd0);
  endtask

  // rsp_ready: random, except when a forced stall of hold_left response cycles is requested
  initial begin
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (hold_left > 0) begin
        bus.rsp_ready = 1'b0;
        if (bus.rsp_valid) hold_left--;
      end else begin
        bus.rsp_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor
  initial begin
    bit seen = 0, hold_v = 0, expect_idle = 0;
    logic [15:0] h_res;
    logic [3:0]  h_tag;
    logic        h_err;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        seen = 0; hold_v = 0; expect_idle = 0;
      end else begin
        if (expect_idle) begin
          check("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
          check("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
          expect_idle = 0;
        end
        if (bus.rsp_valid) begin
          check("busy_cmd_ready", 32'(bus.cmd_ready), 32'd0);
          if (hold_v) begin
            check("hold_result", 32'(bus.rsp_result), 32'(h_res));
            check("hold_tag", 32'(bus.rsp_tag), 32'(h_tag));
            check("hold_err", 32'(bus.rsp_err), 32'(h_err));
          end
          if (!seen) begin
            seen = 1;
            if (sb_q.size() == 0) check("spurious_rsp", 32'd1, 32'd0);
            else check("latency", 32'(cyc + 1 - sb_q[0].acc), 32'(sb_q[0].lat));
          end
          if (bus.rsp_ready) begin
            if (sb_q.size() != 0) begin
              e = sb_q.pop_front();
              check("rsp_result", 32'(bus.rsp_result), 32'(e.res));
              check("rsp_tag", 32'(bus.rsp_tag), 32'(e.tag));
              check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
`ifdef ALU_RSP_PARITY_EN
              check("rsp_parity", 32'(bus.rsp_parity), 32'(^{e.err, e.tag, e.res}));
`endif
            end
            $display("rsp result=%04h tag=%0d err=%0d", bus.rsp_result, bus.rsp_tag, bus.rsp_err);
            seen = 0; hold_v = 0; expect_idle = 1;
          end else begin
            hold_v = 1;
            h_res  = bus.rsp_result;
            h_tag  = bus.rsp_tag;
            h_err  = bus.rsp_err;
          end
        end
      end
    end
  end

  initial begin
    reset_n       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_tag   = '0;
    #1;
    check("reset_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_result", 32'(bus.rsp_result), 32'd0);
    check("reset_rsp_tag", 32'(bus.rsp_tag), 32'd0);
    check("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
    gap(2);
    reset_n = 1'b1;
    #1;
    check("post_reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    gap(1);

    // Directed cases
    send(3'd1, 8'hFF, 8'h01, 4'd3);   // ADD carry -> 0100
    wait_drain();
    send(3'd4, 8'hFF, 8'hFF, 4'd5);   // MUL -> FE01
    wait_drain();
    hold_left = 5;
    send(3'd3, 8'hA5, 8'h0F, 4'd7);   // XOR under 5-cycle stall -> 00AA
    wait_drain();
    send(3'd6, 8'h12, 8'h34, 4'd9);   // illegal op
    send(3'd1, 8'h01, 8'h02, 4'd1);   // ADD -> 0003
    send(3'd1, 8'h01, 8'h00, 4'd0);   // parity case
    send(3'd0, 8'h77, 8'h88, 4'd2);   // NOP
    wait_drain();
    gap(1);

    // Reset during the second EXEC cycle of a MUL aborts it
    send(3'd4, 8'h12, 8'h34, 4'd4);
    gap(1);
    reset_n = 1'b0;
    sb_q.delete();
    #1;
    check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("abort_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("abort_rsp_result", 32'(bus.rsp_result), 32'd0);
    gap(2);
    reset_n = 1'b1;
    gap(3);
    check("no_stale_rsp", 32'(bus.rsp_valid), 32'd0);
    send(3'd2, 8'hF0, 8'h3C, 4'd2);   // AND -> 0030
    wait_drain();

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 4'($urandom));
      if ($urandom_range(0, 2) == 0) gap($urandom_range(1, 4));
    end
    wait_drain();
    gap(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
